// File: rtl/clk_gen_osc_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator reprogramming controller.
// The optional CLK_GEN_OSC_CTRL_RANGE_CHECK_EN build is handled in clk_gen_osc_ctrl.
package clk_gen_osc_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDisable,
        StLoad,
        StEnable,
        StSettle,
        StMeasure,
        StDone
    } osc_state_e;

    localparam int unsigned DefTrimW        = 5;
    localparam int unsigned DefCntW         = 16;
    localparam int unsigned DefDisCycles    = 4;
    localparam int unsigned DefSettleCycles = 64;
    localparam int unsigned DefWindowCycles = 1024;

    // Timer is loaded with (cycles - 1), so $clog2 of the largest count is enough.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int unsigned TimerW = timer_width(DefDisCycles, DefSettleCycles,
                                                 DefWindowCycles);

endpackage

// File: rtl/clk_gen_osc_ctrl_if.sv
// Command/response bundle between the clk_gen config logic (master) and the
// oscillator controller (slave).
interface clk_gen_osc_ctrl_if
    import clk_gen_osc_ctrl_pkg::*;
#(
    parameter int unsigned TRIM_W = DefTrimW,
    parameter int unsigned CNT_W  = DefCntW
);
    logic              cmd_v;
    logic [TRIM_W-1:0] cmd_trim;
    logic              cmd_ready;
    logic              resp_v;
    logic [CNT_W-1:0]  resp_count;
    logic              resp_in_range;
    logic              resp_yumi;

    modport master (
        output cmd_v, cmd_trim, resp_yumi,
        input  cmd_ready, resp_v, resp_count, resp_in_range
    );

    modport slave (
        input  cmd_v, cmd_trim, resp_yumi,
        output cmd_ready, resp_v, resp_count, resp_in_range
    );
endinterface

// File: rtl/clk_gen_toggle_counter.sv
// Edge detector plus saturating toggle counter for the synchronized oscillator tap.
// count_o is the next-state count, so it already includes the current cycle's toggle.
module clk_gen_toggle_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             osc_toggle_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic             prev_q;
    logic             toggle;
    logic [CNT_W-1:0] count_q, count_d;

    assign toggle = osc_toggle_i ^ prev_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && toggle && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            prev_q  <= osc_toggle_i;
            count_q <= count_d;
        end
    end

    assign count_o = count_d;

endmodule

// File: rtl/clk_gen_osc_ctrl.sv
// Sequences oscillator reprogramming: disable, load trim, enable, settle, measure toggles.
// Define CLK_GEN_OSC_CTRL_RANGE_CHECK_EN to compare the count against [CNT_MIN, CNT_MAX].
module clk_gen_osc_ctrl
    import clk_gen_osc_ctrl_pkg::*;
#(
    parameter int unsigned      TRIM_W        = DefTrimW,
    parameter int unsigned      CNT_W         = DefCntW,
    parameter int unsigned      DIS_CYCLES    = DefDisCycles,
    parameter int unsigned      SETTLE_CYCLES = DefSettleCycles,
    parameter int unsigned      WINDOW_CYCLES = DefWindowCycles,
    parameter logic [CNT_W-1:0] CNT_MIN       = '0,
    parameter logic [CNT_W-1:0] CNT_MAX       = '1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    clk_gen_osc_ctrl_if.slave cfg_io,
    input  logic              osc_toggle_i,
    output logic              osc_en_o,
    output logic [TRIM_W-1:0] trim_o
);

    localparam int unsigned CtrTimerW = timer_width(DIS_CYCLES, SETTLE_CYCLES, WINDOW_CYCLES);

    osc_state_e           state_q, state_d;
    logic [CtrTimerW-1:0] timer_q, timer_d;
    logic                 timer_zero;

    logic              cmd_ready;
    logic              resp_v;
    logic              accept;
    logic              load_trim;
    logic              enable_osc;
    logic              cnt_clear;
    logic              cnt_en;
    logic              capture;

    logic [TRIM_W-1:0] trim_lat_q;
    logic [TRIM_W-1:0] trim_q;
    logic              osc_en_q;
    logic [CNT_W-1:0]  resp_count_q;
    logic [CNT_W-1:0]  cnt;

    assign timer_zero = (timer_q == '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // One down-counter serves every timed state; it is reloaded on each entry.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_io.cmd_v) begin
                    state_d = StDisable;
                    timer_d = CtrTimerW'(DIS_CYCLES - 1);
                end
            end
            StDisable: begin
                if (timer_zero) state_d = StLoad;
                else            timer_d = timer_q - 1'b1;
            end
            StLoad: begin
                state_d = StEnable;
            end
            StEnable: begin
                state_d = StSettle;
                timer_d = CtrTimerW'(SETTLE_CYCLES - 1);
            end
            StSettle: begin
                if (timer_zero) begin
                    state_d = StMeasure;
                    timer_d = CtrTimerW'(WINDOW_CYCLES - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StMeasure: begin
                if (timer_zero) state_d = StDone;
                else            timer_d = timer_q - 1'b1;
            end
            StDone: begin
                if (cfg_io.resp_yumi) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == StIdle);
        resp_v     = (state_q == StDone);
        accept     = cmd_ready && cfg_io.cmd_v;
        load_trim  = (state_q == StDisable) && timer_zero;
        enable_osc = (state_q == StLoad);
        cnt_clear  = (state_q == StSettle) && timer_zero;
        cnt_en     = (state_q == StMeasure);
        capture    = cnt_en && timer_zero;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            trim_lat_q   <= '0;
            trim_q       <= '0;
            osc_en_q     <= 1'b0;
            resp_count_q <= '0;
        end else begin
            if (accept)     trim_lat_q   <= cfg_io.cmd_trim;
            if (load_trim)  trim_q       <= trim_lat_q;
            if (accept)     osc_en_q     <= 1'b0;
            if (enable_osc) osc_en_q     <= 1'b1;
            if (capture)    resp_count_q <= cnt;
        end
    end

    clk_gen_toggle_counter #(
        .CNT_W (CNT_W)
    ) u_toggle_counter (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .osc_toggle_i (osc_toggle_i),
        .clear_i      (cnt_clear),
        .en_i         (cnt_en),
        .count_o      (cnt)
    );

`ifdef CLK_GEN_OSC_CTRL_RANGE_CHECK_EN
    logic in_range_q, in_range_d;

    // An all-ones count may hide an overflow, so it is never reported in range.
    assign in_range_d = (cnt != '1) && (cnt >= CNT_MIN) && (cnt <= CNT_MAX);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)      in_range_q <= 1'b0;
        else if (capture) in_range_q <= in_range_d;
    end

    assign cfg_io.resp_in_range = in_range_q;
`else
    logic unused_bounds;
    assign unused_bounds        = ^{CNT_MIN, CNT_MAX};
    assign cfg_io.resp_in_range = resp_v;
`endif

    assign cfg_io.cmd_ready  = cmd_ready;
    assign cfg_io.resp_v     = resp_v;
    assign cfg_io.resp_count = resp_count_q;
    assign osc_en_o          = osc_en_q;
    assign trim_o            = trim_q;

endmodule
